stream_demux6: RTL and testbench
================================

Name: stream_demux6

Overview:
- Inverse of the team's 6-way select mux: steers one 4-bit input stream to one of six output channels, chosen by a 3-bit select.
- Each channel has a one-entry registered holding slot with a valid/ready handshake, so a stalled consumer blocks only traffic addressed to it.
- Select codes 6 and 7 are illegal. Such beats are accepted, discarded, and counted.
- Sits between a single producer and six independent consumers in the datapath.

Parameters:
- DATA_W, 4, payload width per beat.
- DROP_W, 8, width of the saturating illegal-select drop counter.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_sel  in  3  destination channel; 0..5 legal, 6..7 illegal.
- in_data  in  DATA_W  payload.
- out_valid  out  6  bit k set means channel k holds a beat.
- out_ready  in  6  bit k set means consumer k takes the beat this cycle.
- out_data  out  6*DATA_W  channel k payload is bits [k*DATA_W +: DATA_W].
- drop_count  out  DROP_W  number of illegal-select beats discarded; saturates.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - out_valid = 0, out_data = 0, drop_count = 0.
  - in_ready is combinational and evaluates to 1 after reset.
  - Reset overrides every other event in that cycle. Beats held in slots are lost and not counted.
- Handshakes:
  - Input accept: in_valid && in_ready at a clk edge.
  - Output k transfer: out_valid[k] && out_ready[k] at a clk edge.
- Per-channel slot has two states, EMPTY and FULL:
  - EMPTY -> FULL: accept with in_sel==k.
  - FULL -> EMPTY: transfer on k with no accept to k in the same cycle.
  - FULL -> FULL: accept to k and transfer on k in the same cycle. Slot loads the new payload; out_valid[k] stays 1.
  - FULL with no transfer and no accept to k: hold; payload is stable.
- in_ready:
  - in_sel 0..5: in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is pass-through ready, giving full throughput to one channel.
  - in_sel 6..7: in_ready = 1.
  - in_ready depends only on in_sel, out_valid and out_ready, never on in_valid. in_ready is meaningful only while in_valid=1.
- Latency: a beat accepted at edge N drives out_valid/out_data from edge N onward and is first transferable at edge N+1. Exactly one cycle; no combinational path from in_data to out_data.
- Ordering: beats to the same channel leave in acceptance order. Channels are independent; a full channel k does not stall beats to channel j≠k.
- out_data[k] holds its last value while EMPTY; consumers ignore it.
- Illegal select: accepted beat with in_sel≥6 does not touch any slot. drop_count increments by 1, saturating at 2^DROP_W−1 (no wrap).
- Producer obligation: hold in_valid, in_sel and in_data stable until accepted. The bench checks this; the block does not rely on it.

Decomposition:
- Package stream_demux_pkg holds:
  - NUM_CH=6, SEL_W=3, DEFAULT DATA_W=4.
  - typedef ch_sel_t (logic [SEL_W-1:0]).
  - function sel_legal (sel < NUM_CH).
- Sub-module demux_slot: one-entry register slice.
  - Ports: clk, reset, load, load_data, valid, ready, data, slot_ready.
  - Instantiated six times in a generate loop.
- Top level holds the select decode, the in_ready mux and the drop counter.

Test Plan:
- Reset then idle -> out_valid=6'b0, out_data=0, drop_count=0; in_ready=1 for in_sel=2.
- in_sel=3, in_data=4'hA, all out_ready=0 -> next cycle out_valid=6'b001000, channel 3 data=4'hA. A second beat to channel 3 sees in_ready=0; a beat in_sel=1, data 4'h5 is accepted, and out_valid becomes 6'b001010.
- Stream 4'h1..4'h8 to channel 0 with out_ready[0]=1 continuously -> one beat per cycle, in order, in_ready held at 1, 1-cycle latency.
- Channel 5 FULL with 4'hC; same cycle out_ready[5]=1 and accept in_sel=5, data 4'hD -> out_valid[5] stays 1, data becomes 4'hD, 4'hC consumed exactly once.
- in_sel=6 then in_sel=7, in_valid=1, with DROP_W=2 and 5 such beats -> in_ready=1 each cycle, out_valid unchanged, drop_count 1,2,3,3,3.
- Channels 0 and 4 FULL, reset asserted for one cycle mid-stream with in_valid=1 -> next cycle out_valid=0, drop_count=0, the beat offered during reset not captured.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants, select type and legality helper for stream_demux6
package stream_demux_pkg;

    localparam int NUM_CH         = 6;
    localparam int SEL_W          = 3;
    localparam int DATA_W_DEFAULT = 4;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Codes at or above the channel count address no slot and are dropped
    function automatic logic sel_legal(input ch_sel_t sel);
        return int'(sel) < NUM_CH;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry registered holding slot with valid/ready handshake
module demux_slot #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              slot_ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Slot can take a beat when empty or when its content leaves this cycle
    assign slot_ready = !valid_q || ready;

    // Next state: a load always leaves the slot full; otherwise a transfer empties it
    always_comb begin
        valid_d = load || (valid_q && !ready);
        data_d  = load ? load_data : data_q;
    end

    // State register; payload is kept while empty so consumers see a stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/stream_demux6.sv
// rtl/stream_demux6.sv - steers one input stream to six buffered channels, drops illegal selects
module stream_demux6
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [DROP_W-1:0]        drop_count
);

    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] load;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic              accept;
    logic [DROP_W-1:0] drop_q, drop_d;

    // Ready follows the addressed slot; illegal selects are always taken so they can be dropped
    always_comb begin
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == ch_sel_t'(k)) begin
                in_ready = slot_ready[k];
            end
        end
    end

    assign accept = in_valid && in_ready;

    // One-hot load strobe toward the addressed slot
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (in_sel == ch_sel_t'(k));
        end
    end

    // Drop counter next state: count accepted illegal beats, stick at all-ones
    always_comb begin
        drop_d = drop_q;
        if (accept && !sel_legal(in_sel) && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (load[k]),
            .load_data  (in_data),
            .valid      (out_valid[k]),
            .ready      (out_ready[k]),
            .data       (slot_data[k]),
            .slot_ready (slot_ready[k])
        );
        assign out_data[k*DATA_W +: DATA_W] = slot_data[k];
    end

endmodule

// File: tb/tb_stream_demux6.sv
// tb/tb_stream_demux6.sv - self-checking bench for stream_demux6 with directed table and random traffic
module tb_stream_demux6;

    localparam int NCH   = 6;
    localparam int DW    = 4;
    localparam int DRW   = 2;
    localparam int DMAX  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_sel;
    logic [DW-1:0]     in_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_data;
    logic [DRW-1:0]    drop_count;

    stream_demux6 #(
        .DATA_W (DW),
        .DROP_W (DRW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel FIFO of accepted, not yet consumed beats
    typedef logic [DW-1:0] beat_q_t [$];
    beat_q_t m_q [NCH];
    int      m_drops;

    int   n_vec;
    int   n_err;
    logic last_rdy;
    logic last_acc;

    typedef struct {
        logic           v;
        logic [2:0]     sel;
        logic [DW-1:0]  d;
        logic [NCH-1:0] ordy;
        logic           rdy;
        logic [NCH-1:0] val;
        logic [DRW-1:0] drop;
        int             ch;
        logic [DW-1:0]  cd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic [2:0] sel, input logic [NCH-1:0] ordy);
        if (int'(sel) >= NCH) return 1'b1;
        return (m_q[sel].size() == 0) || ordy[sel];
    endfunction

    task automatic check_state();
        logic [NCH-1:0] ev;
        for (int k = 0; k < NCH; k++) begin
            ev[k] = (m_q[k].size() != 0);
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        for (int k = 0; k < NCH; k++) begin
            if (m_q[k].size() != 0) begin
                chk($sformatf("out_data_ch%0d", k), 32'(out_data[k*DW +: DW]), 32'(m_q[k][0]));
            end
        end
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    // One clock: drive inputs, check combinational ready, advance model at the edge, check state
    task automatic cyc(input logic rst, input logic v, input logic [2:0] sel,
                       input logic [DW-1:0] d, input logic [NCH-1:0] ordy);
        logic exp_rdy;
        reset     = rst;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy  = model_ready(sel, ordy);
        last_rdy = in_ready;
        if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        last_acc = v && exp_rdy && !rst;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NCH; k++) m_q[k].delete();
            m_drops = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (m_q[k].size() != 0 && ordy[k]) void'(m_q[k].pop_front());
            end
            if (last_acc) begin
                if (int'(sel) < NCH) m_q[sel].push_back(d);
                else if (m_drops < DMAX) m_drops++;
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        logic           rv;
        logic [2:0]     rsel;
        logic [DW-1:0]  rd;
        n_vec   = 0;
        n_err   = 0;
        m_drops = 0;

        // Reset then idle
        cyc(1'b1, 1'b0, 3'd0, 4'h0, 6'h00);
        cyc(1'b1, 1'b0, 3'd0, 4'h0, 6'h00);
        chk("reset_out_data", 32'(out_data), 32'h0);
        cyc(1'b0, 1'b0, 3'd2, 4'h0, 6'h00);
        chk("idle_ready_sel2", 32'(last_rdy), 32'h1);

        // Directed table: fill/block, side channel, drain, illegal selects, same-cycle reload
        tbl[0]  = '{1'b1, 3'd3, 4'hA, 6'b000000, 1'b1, 6'b001000, 2'd0, 3, 4'hA};
        tbl[1]  = '{1'b1, 3'd3, 4'hB, 6'b000000, 1'b0, 6'b001000, 2'd0, 3, 4'hA};
        tbl[2]  = '{1'b1, 3'd1, 4'h5, 6'b000000, 1'b1, 6'b001010, 2'd0, 1, 4'h5};
        tbl[3]  = '{1'b0, 3'd0, 4'h0, 6'b001010, 1'b1, 6'b000000, 2'd0, 9, 4'h0};
        tbl[4]  = '{1'b1, 3'd6, 4'h1, 6'b000000, 1'b1, 6'b000000, 2'd1, 9, 4'h0};
        tbl[5]  = '{1'b1, 3'd7, 4'h2, 6'b000000, 1'b1, 6'b000000, 2'd2, 9, 4'h0};
        tbl[6]  = '{1'b1, 3'd6, 4'h3, 6'b000000, 1'b1, 6'b000000, 2'd3, 9, 4'h0};
        tbl[7]  = '{1'b1, 3'd7, 4'h4, 6'b000000, 1'b1, 6'b000000, 2'd3, 9, 4'h0};
        tbl[8]  = '{1'b1, 3'd6, 4'h5, 6'b000000, 1'b1, 6'b000000, 2'd3, 9, 4'h0};
        tbl[9]  = '{1'b1, 3'd5, 4'hC, 6'b000000, 1'b1, 6'b100000, 2'd3, 5, 4'hC};
        tbl[10] = '{1'b1, 3'd5, 4'hD, 6'b100000, 1'b1, 6'b100000, 2'd3, 5, 4'hD};
        tbl[11] = '{1'b0, 3'd0, 4'h0, 6'b100000, 1'b1, 6'b000000, 2'd3, 9, 4'h0};
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_ready", i), 32'(last_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].val));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(tbl[i].drop));
            if (tbl[i].ch < NCH) begin
                chk($sformatf("tbl%0d_data", i), 32'(out_data[tbl[i].ch*DW +: DW]), 32'(tbl[i].cd));
            end
        end

        // Full-throughput stream to channel 0
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 3'd0, DW'(i), 6'b000001);
            chk("stream_ready", 32'(last_rdy), 32'h1);
            chk("stream_valid0", 32'(out_valid[0]), 32'h1);
            chk("stream_data0", 32'(out_data[DW-1:0]), 32'(i));
        end
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 6'b000001);
        chk("stream_drained", 32'(out_valid), 32'h0);

        // Randomized traffic, producer holds an offered beat until accepted
        cyc(1'b1, 1'b0, 3'd0, 4'h0, 6'h00);
        rv = 1'b0; rsel = 3'd0; rd = 4'h0; last_acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!rv || last_acc) begin
                rv   = ($urandom_range(0, 3) != 0);
                rsel = 3'($urandom_range(0, 7));
                rd   = 4'($urandom);
            end
            cyc(1'b0, rv, rsel, rd, 6'($urandom));
        end

        // Reset mid-stream with channels 0 and 4 full and a beat offered
        cyc(1'b1, 1'b0, 3'd0, 4'h0, 6'h00);
        cyc(1'b0, 1'b1, 3'd0, 4'h3, 6'h00);
        cyc(1'b0, 1'b1, 3'd4, 4'h9, 6'h00);
        chk("pre_reset_valid", 32'(out_valid), 32'b010001);
        cyc(1'b1, 1'b1, 3'd2, 4'h7, 6'h00);
        chk("post_reset_valid", 32'(out_valid), 32'h0);
        chk("post_reset_drop", 32'(drop_count), 32'h0);
        chk("post_reset_data", 32'(out_data), 32'h0);
        cyc(1'b0, 1'b0, 3'd2, 4'h0, 6'h00);
        chk("reset_beat_not_captured", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
